// File: rtl/panel_bridge_pkg.sv
// panel_bridge_pkg
//   Shared constants and types for the serial front-panel bridge:
//   command opcodes, ACK/NAK bytes, key-code and register-select
//   enumerations, and the command FSM state type.
package panel_bridge_pkg;

    localparam logic [7:0] OP_SR    = 8'h53;  // 'S' switch register
    localparam logic [7:0] OP_FIELD = 8'h46;  // 'F' field switches
    localparam logic [7:0] OP_MODE  = 8'h4D;  // 'M' mode switches
    localparam logic [7:0] OP_KEY   = 8'h4B;  // 'K' key pulse
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R' register read

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    localparam int NUM_KEYS = 6;

    typedef enum logic [2:0] {
        KEY_START     = 3'd0,
        KEY_STOP      = 3'd1,
        KEY_LOAD_ADDR = 3'd2,
        KEY_DEP       = 3'd3,
        KEY_EXAM      = 3'd4,
        KEY_CONT      = 3'd5
    } key_e;

    typedef enum logic [2:0] {
        SEL_PC     = 3'd0,
        SEL_MA     = 3'd1,
        SEL_MB     = 3'd2,
        SEL_LAC    = 3'd3,
        SEL_MQ     = 3'd4,
        SEL_STATUS = 3'd5
    } sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG0,
        ST_ARG1,
        ST_EXEC,
        ST_PULSE,
        ST_SEND_ACK,
        ST_SEND_HI,
        ST_SEND_LO
    } state_e;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_SR) || (b == OP_FIELD) || (b == OP_MODE) ||
               (b == OP_KEY) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/panel_uart_bridge_uart_byte_io.sv
// uart_byte_io
//   8N1 byte-level UART. Receiver uses a 2-flop synchronizer and 16x
//   oversampling (start bit re-checked at its midpoint, data and stop
//   sampled mid-bit). Transmitter sends start, 8 data bits LSB first, stop.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rx                   serial input, idle high
//   rx_data, rx_valid    received byte and its 1-cycle strobe
//   tx                   serial output, idle high
//   tx_data, tx_start    byte to send; start accepted only when !tx_busy
//   tx_busy              high while a byte is on the line
module uart_byte_io #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy
);

    localparam int OS_RAW  = CLK_HZ / (BAUD * 16);
    localparam int OS_DIV  = (OS_RAW < 1) ? 1 : OS_RAW;
    localparam int BIT_CYC = OS_DIV * 16;
    localparam int OW      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int BW      = $clog2(BIT_CYC);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // receiver state
    logic            rx_meta_q, rx_sync_q;
    logic [OW-1:0]   os_q, os_d;
    rx_state_e       rx_state_q, rx_state_d;
    logic [3:0]      rx_tick_q, rx_tick_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid_q, rx_valid_d;
    logic            os_tick;

    // transmitter state
    logic            tx_q, tx_d;
    logic            tx_busy_q, tx_busy_d;
    logic [9:0]      tx_shift_q, tx_shift_d;
    logic [BW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bits_q, tx_bits_d;

    assign os_tick  = (os_q == OW'(OS_DIV - 1));
    assign rx_data  = rx_shift_q;
    assign rx_valid = rx_valid_q;
    assign tx       = tx_q;
    assign tx_busy  = tx_busy_q;

    always_comb begin
        os_d       = os_tick ? '0 : os_q + 1'b1;
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = '0;
                end
            end
            RX_START: begin
                if (os_tick) begin
                    if (rx_tick_q == 4'd7) begin
                        // a glitch shorter than half a bit is not a start bit
                        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                    end else begin
                        rx_tick_d = rx_tick_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (os_tick) begin
                    if (rx_tick_q == 4'd15) begin
                        rx_tick_d  = '0;
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = RX_STOP;
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (os_tick) begin
                    if (rx_tick_q == 4'd15) begin
                        // framing error: drop the byte silently
                        rx_valid_d = rx_sync_q;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_tick_d = rx_tick_q + 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bits_d  = tx_bits_q;

        if (!tx_busy_q) begin
            if (tx_start) begin
                tx_shift_d = {1'b1, tx_data, 1'b0};
                tx_busy_d  = 1'b1;
                tx_cnt_d   = '0;
                tx_bits_d  = '0;
                tx_d       = 1'b0;
            end
        end else if (tx_cnt_q == BW'(BIT_CYC - 1)) begin
            tx_cnt_d   = '0;
            tx_bits_d  = tx_bits_q + 1'b1;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            if (tx_bits_q == 4'd9) begin
                tx_busy_d = 1'b0;
                tx_d      = 1'b1;
            end else begin
                tx_d = tx_shift_d[0];
            end
        end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        rx_shift_q <= rx_shift_d;
        tx_shift_q <= tx_shift_d;
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            os_q       <= '0;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_valid_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bits_q  <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            os_q       <= os_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_valid_q <= rx_valid_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bits_q  <= tx_bits_d;
        end
    end

endmodule

// File: rtl/panel_uart_bridge.sv
// panel_uart_bridge
//   Host-UART front panel for the PDP-8/I. Decodes binary commands
//   (S/F/M/K/R), drives switch register, field and mode switches, pulses
//   one key at a time, and returns register snapshots. Every command is
//   answered with ACK or NAK; a NAK'd command leaves every output alone.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rx, tx                    host serial lines (8N1, idle high)
//   sr, dfsr, ifsr            switch register and field switches
//   start..cont               key outputs, high for PULSE_CYCLES
//   step, sing_step, sing_inst mode switch levels
//   run, pause, ion           processor status inputs
//   pc, ma, mb, mq, lac       processor registers (lac = link + AC)
//   instf, dataf              field registers
module panel_uart_bridge #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int BAUD           = 115200,
    parameter int PULSE_CYCLES   = 1000,
    parameter int TIMEOUT_CYCLES = CLK_HZ / 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    output logic [11:0] sr,
    output logic [2:0]  dfsr,
    output logic [2:0]  ifsr,
    output logic        start,
    output logic        stop,
    output logic        load_addr,
    output logic        dep,
    output logic        exam,
    output logic        cont,
    output logic        step,
    output logic        sing_step,
    output logic        sing_inst,
    input  logic        run,
    input  logic        pause,
    input  logic        ion,
    input  logic [11:0] pc,
    input  logic [11:0] ma,
    input  logic [11:0] mb,
    input  logic [11:0] mq,
    input  logic [12:0] lac,
    input  logic [2:0]  instf,
    input  logic [2:0]  dataf
);

    import panel_bridge_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    uart_byte_io #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx       (tx),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    state_e              state_q, state_d;
    logic [7:0]          opcode_q, opcode_d;
    logic [7:0]          arg0_q, arg0_d;
    logic [7:0]          arg1_q, arg1_d;
    logic [7:0]          resp_q, resp_d;
    logic [12:0]         snap_q, snap_d;
    logic                sent_q, sent_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PW-1:0]       pulse_q, pulse_d;
    logic [11:0]         sr_q, sr_d;
    logic [2:0]          dfsr_q, dfsr_d;
    logic [2:0]          ifsr_q, ifsr_d;
    logic [2:0]          mode_q, mode_d;   // {step, sing_step, sing_inst}
    logic [NUM_KEYS-1:0] keys_q, keys_d;   // one-hot, indexed by key_e

    logic [12:0] read_v;
    logic        send_ready;
    logic        send_done;

    assign sr        = sr_q;
    assign dfsr      = dfsr_q;
    assign ifsr      = ifsr_q;
    assign step      = mode_q[2];
    assign sing_step = mode_q[1];
    assign sing_inst = mode_q[0];
    assign start     = keys_q[KEY_START];
    assign stop      = keys_q[KEY_STOP];
    assign load_addr = keys_q[KEY_LOAD_ADDR];
    assign dep       = keys_q[KEY_DEP];
    assign exam      = keys_q[KEY_EXAM];
    assign cont      = keys_q[KEY_CONT];

    // sent_q marks that this SEND state already issued its byte; the state
    // is left once the transmitter has gone busy and come back idle.
    assign send_ready = !sent_q && !tx_busy;
    assign send_done  = sent_q && !tx_busy;

    always_comb begin
        read_v = '0;
        case (arg0_q[2:0])
            SEL_PC:     read_v = {1'b0, pc};
            SEL_MA:     read_v = {1'b0, ma};
            SEL_MB:     read_v = {1'b0, mb};
            SEL_LAC:    read_v = lac;
            SEL_MQ:     read_v = {1'b0, mq};
            SEL_STATUS: read_v = {4'b0, run, pause, ion, instf, dataf};
            default:    read_v = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        arg0_d   = arg0_q;
        arg1_d   = arg1_q;
        resp_d   = resp_q;
        snap_d   = snap_q;
        sent_d   = sent_q;
        timer_d  = timer_q;
        pulse_d  = pulse_q;
        sr_d     = sr_q;
        dfsr_d   = dfsr_q;
        ifsr_d   = ifsr_q;
        mode_d   = mode_q;
        keys_d   = keys_q;
        tx_start = 1'b0;
        tx_data  = resp_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    opcode_d = rx_data;
                    timer_d  = '0;
                    sent_d   = 1'b0;
                    if (is_opcode(rx_data)) begin
                        state_d = ST_ARG0;
                    end else begin
                        resp_d  = NAK;
                        state_d = ST_SEND_ACK;
                    end
                end
            end
            ST_ARG0: begin
                if (rx_valid) begin
                    arg0_d  = rx_data;
                    timer_d = '0;
                    state_d = (opcode_q == OP_SR) ? ST_ARG1 : ST_EXEC;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ARG1: begin
                if (rx_valid) begin
                    arg1_d  = rx_data;
                    timer_d = '0;
                    state_d = ST_EXEC;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_EXEC: begin
                resp_d  = ACK;
                sent_d  = 1'b0;
                state_d = ST_SEND_ACK;
                case (opcode_q)
                    OP_SR:    sr_d = {arg0_q[3:0], arg1_q};
                    OP_FIELD: begin
                        ifsr_d = arg0_q[5:3];
                        dfsr_d = arg0_q[2:0];
                    end
                    OP_MODE:  mode_d = arg0_q[2:0];
                    OP_KEY: begin
                        // only stop may be pressed while the machine runs
                        if ((arg0_q > 8'd5) || (run && (arg0_q[2:0] != KEY_STOP))) begin
                            resp_d = NAK;
                        end else begin
                            keys_d  = NUM_KEYS'(1) << arg0_q[2:0];
                            pulse_d = '0;
                            state_d = ST_PULSE;
                        end
                    end
                    OP_READ: begin
                        if (arg0_q > 8'd5) begin
                            resp_d = NAK;
                        end else begin
                            snap_d = read_v;
                        end
                    end
                    default: resp_d = NAK;
                endcase
            end
            ST_PULSE: begin
                if (pulse_q == PW'(PULSE_CYCLES - 1)) begin
                    keys_d  = '0;
                    state_d = ST_SEND_ACK;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            ST_SEND_ACK: begin
                tx_data = resp_q;
                if (send_ready) begin
                    tx_start = 1'b1;
                    sent_d   = 1'b1;
                end else if (send_done) begin
                    sent_d  = 1'b0;
                    state_d = (opcode_q == OP_READ && resp_q == ACK) ? ST_SEND_HI : ST_IDLE;
                end
            end
            ST_SEND_HI: begin
                tx_data = {1'b0, snap_q[12:6]};
                if (send_ready) begin
                    tx_start = 1'b1;
                    sent_d   = 1'b1;
                end else if (send_done) begin
                    sent_d  = 1'b0;
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                tx_data = {2'b0, snap_q[5:0]};
                if (send_ready) begin
                    tx_start = 1'b1;
                    sent_d   = 1'b1;
                end else if (send_done) begin
                    sent_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        opcode_q <= opcode_d;
        arg0_q   <= arg0_d;
        arg1_q   <= arg1_d;
        resp_q   <= resp_d;
        snap_q   <= snap_d;
        if (rst) begin
            state_q <= ST_IDLE;
            sent_q  <= 1'b0;
            timer_q <= '0;
            pulse_q <= '0;
            sr_q    <= '0;
            dfsr_q  <= '0;
            ifsr_q  <= '0;
            mode_q  <= '0;
            keys_q  <= '0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            sr_q    <= sr_d;
            dfsr_q  <= dfsr_d;
            ifsr_q  <= ifsr_d;
            mode_q  <= mode_d;
            keys_q  <= keys_d;
        end
    end

endmodule

// File: tb/tb_panel_uart_bridge.sv
module tb_panel_uart_bridge;

    localparam int CLK_HZ  = 3_200_000;
    localparam int BAUD    = 100_000;
    localparam int PULSE   = 40;
    localparam int TIMEOUT = 2000;
    localparam int BIT     = CLK_HZ / BAUD;   // 32 clocks per bit

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        tx;
    logic [11:0] sr;
    logic [2:0]  dfsr, ifsr;
    logic        start, stop, load_addr, dep, exam, cont;
    logic        step, sing_step, sing_inst;
    logic        run = 1'b0, pause = 1'b0, ion = 1'b0;
    logic [11:0] pc = '0, ma = '0, mb = '0, mq = '0;
    logic [12:0] lac = '0;
    logic [2:0]  instf = '0, dataf = '0;

    panel_uart_bridge #(
        .CLK_HZ         (CLK_HZ),
        .BAUD           (BAUD),
        .PULSE_CYCLES   (PULSE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .tx        (tx),
        .sr        (sr),
        .dfsr      (dfsr),
        .ifsr      (ifsr),
        .start     (start),
        .stop      (stop),
        .load_addr (load_addr),
        .dep       (dep),
        .exam      (exam),
        .cont      (cont),
        .step      (step),
        .sing_step (sing_step),
        .sing_inst (sing_inst),
        .run       (run),
        .pause     (pause),
        .ion       (ion),
        .pc        (pc),
        .ma        (ma),
        .mb        (mb),
        .mq        (mq),
        .lac       (lac),
        .instf     (instf),
        .dataf     (dataf)
    );

    always #5 clk = ~clk;

    wire [5:0] keys_w = {cont, exam, dep, load_addr, stop, start};

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // key pulse tracker, sampled on the falling edge
    int        cyc       = 0;
    int        cur_len   = 0;
    int        last_len  = 0;
    int        pulse_cnt = 0;
    int        fall_cyc  = 0;
    logic [5:0] last_key = '0;
    logic      multi_key = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if ($countones(keys_w) > 1) multi_key <= 1'b1;
        if (keys_w != 0) begin
            cur_len  <= cur_len + 1;
            last_key <= keys_w;
        end else if (cur_len != 0) begin
            last_len  <= cur_len;
            cur_len   <= 0;
            pulse_cnt <= pulse_cnt + 1;
            fall_cyc  <= cyc;
        end
    end

    // tx byte monitor
    logic [7:0] mon_bytes [0:63];
    int         mon_start [0:63];
    int         mon_cnt = 0;

    initial begin
        logic [7:0] b;
        int         sc;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                sc = cyc;
                repeat (BIT / 2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT) @(negedge clk);
                        b[i] = tx;
                    end
                    repeat (BIT) @(negedge clk);
                    if (mon_cnt < 64) begin
                        mon_bytes[mon_cnt] = b;
                        mon_start[mon_cnt] = sc;
                        mon_cnt = mon_cnt + 1;
                    end
                end
            end
        end
    end

    int rd_ptr = 0;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        while (rd_ptr >= mon_cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (rd_ptr < mon_cnt) begin
            check_eq(tag, {24'b0, mon_bytes[rd_ptr]}, {24'b0, exp});
            rd_ptr++;
        end else begin
            check_eq({tag, "_timeout"}, 32'h100, {24'b0, exp});
        end
    endtask

    initial begin
        int pc0;
        int n;

        // reset state
        repeat (5) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_sr", sr, 0);
        check_eq("rst_keys", keys_w, 0);
        check_eq("rst_fields", {ifsr, dfsr}, 0);
        check_eq("rst_modes", {step, sing_step, sing_inst}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rd_ptr = mon_cnt;

        // 'S' 0x0F 0xFF -> sr = 7777
        send_byte(8'h53); send_byte(8'h0F); send_byte(8'hFF);
        expect_byte("s_ack", 8'h06);
        check_eq("s_sr", sr, 12'o7777);

        // 'F' 0x2B -> ifsr 5, dfsr 3
        send_byte(8'h46); send_byte(8'h2B);
        expect_byte("f_ack", 8'h06);
        check_eq("f_ifsr", ifsr, 3'd5);
        check_eq("f_dfsr", dfsr, 3'd3);

        // 'M' 0x03
        send_byte(8'h4D); send_byte(8'h03);
        expect_byte("m_ack", 8'h06);
        check_eq("m_modes", {step, sing_step, sing_inst}, 3'b011);

        // 'K' dep with run = 0
        pc0 = pulse_cnt;
        send_byte(8'h4B); send_byte(8'h03);
        expect_byte("k_dep_ack", 8'h06);
        check_eq("k_dep_pulses", pulse_cnt - pc0, 1);
        check_eq("k_dep_len", last_len, PULSE);
        check_eq("k_dep_which", last_key, 6'b001000);
        check_eq("k_ack_after_fall", (mon_start[rd_ptr-1] >= fall_cyc), 1);

        // 'K' dep with run = 1 -> NAK, no pulse
        run = 1'b1;
        pc0 = pulse_cnt;
        send_byte(8'h4B); send_byte(8'h03);
        expect_byte("k_run_nak", 8'h15);
        check_eq("k_run_nopulse", pulse_cnt - pc0, 0);

        // 'K' stop with run = 1 -> pulse, ACK
        pc0 = pulse_cnt;
        send_byte(8'h4B); send_byte(8'h01);
        expect_byte("k_stop_ack", 8'h06);
        check_eq("k_stop_pulses", pulse_cnt - pc0, 1);
        check_eq("k_stop_len", last_len, PULSE);
        check_eq("k_stop_which", last_key, 6'b000010);
        run = 1'b0;

        // 'K' code 7 -> NAK
        pc0 = pulse_cnt;
        send_byte(8'h4B); send_byte(8'h07);
        expect_byte("k_bad_nak", 8'h15);
        check_eq("k_bad_nopulse", pulse_cnt - pc0, 0);

        // 'R' lac = 10123 -> 06 41 13, changing lac mid-reply
        lac = 13'o10123;
        send_byte(8'h52); send_byte(8'h03);
        expect_byte("r_lac_ack", 8'h06);
        lac = 13'o07777;
        expect_byte("r_lac_hi", 8'h41);
        expect_byte("r_lac_lo", 8'h13);

        // 'R' select 6 -> NAK only
        send_byte(8'h52); send_byte(8'h06);
        expect_byte("r_bad_nak", 8'h15);

        // unknown opcode
        send_byte(8'h99);
        expect_byte("unk_nak", 8'h15);

        // truncated 'S' times out silently
        send_byte(8'h53); send_byte(8'h01);
        repeat (TIMEOUT + 400) @(negedge clk);
        check_eq("timeout_silent", mon_cnt - rd_ptr, 0);
        check_eq("timeout_sr", sr, 12'o7777);

        // 'R' pc after timeout: pc = 1234 -> 0A 1C
        pc = 12'o1234;
        send_byte(8'h52); send_byte(8'h00);
        expect_byte("r_pc_ack", 8'h06);
        expect_byte("r_pc_hi", 8'h0A);
        expect_byte("r_pc_lo", 8'h1C);

        // 'R' status: run0 pause1 ion1 instf5 dataf2 -> 0xEA -> 03 2A
        pause = 1'b1; ion = 1'b1; instf = 3'd5; dataf = 3'd2;
        send_byte(8'h52); send_byte(8'h05);
        expect_byte("r_st_ack", 8'h06);
        expect_byte("r_st_hi", 8'h03);
        expect_byte("r_st_lo", 8'h2A);

        check_eq("one_key_at_a_time", multi_key, 0);

        // rst during a start pulse
        send_byte(8'h4B); send_byte(8'h00);
        n = 0;
        while (!start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("rstk_start_high", start, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstk_keys", keys_w, 0);
        check_eq("rstk_tx", tx, 1);
        check_eq("rstk_sr", sr, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rd_ptr = mon_cnt;

        // next command works
        send_byte(8'h4D); send_byte(8'h04);
        expect_byte("post_rst_ack", 8'h06);
        check_eq("post_rst_modes", {step, sing_step, sing_inst}, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
